// File: rtl/y86_pkg.sv
// y86_pkg: register index constants and index helpers shared by the Y86 register file.
package y86_pkg;

  typedef logic [3:0] regidx_t;

  localparam regidx_t RAX   = 4'h0;
  localparam regidx_t RCX   = 4'h1;
  localparam regidx_t RDX   = 4'h2;
  localparam regidx_t RBX   = 4'h3;
  localparam regidx_t RSP   = 4'h4;
  localparam regidx_t RBP   = 4'h5;
  localparam regidx_t RSI   = 4'h6;
  localparam regidx_t RDI   = 4'h7;
  localparam regidx_t R8    = 4'h8;
  localparam regidx_t R9    = 4'h9;
  localparam regidx_t R10   = 4'hA;
  localparam regidx_t R11   = 4'hB;
  localparam regidx_t R12   = 4'hC;
  localparam regidx_t R13   = 4'hD;
  localparam regidx_t R14   = 4'hE;
  localparam regidx_t RNONE = 4'hF;

  // NREGS never exceeds 2^ADDR_W - 1, so the all-ones RNONE index is always out of range.
  function automatic logic is_none(input int unsigned idx, input int unsigned nregs);
    return idx >= nregs;
  endfunction

endpackage

// File: rtl/y86_sb_counter.sv
// y86_sb_counter: saturating up/down count of outstanding writes to one register.
// Build option: REGFILE_BYPASS_EN adds the 'last' output (exactly one write outstanding).
module y86_sb_counter #(
  parameter int MAX = 3,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full,
  output logic underflow
`ifdef REGFILE_BYPASS_EN
  ,
  output logic last
`endif
);

  logic [CW-1:0] cnt;

  assign zero      = (cnt == '0);
  assign full      = (cnt == CW'(MAX));
  assign underflow = dec & ~inc & zero;

`ifdef REGFILE_BYPASS_EN
  assign last = (cnt == CW'(1));
`endif

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc & ~dec & ~full) begin
      cnt <= cnt + 1'b1;
    end else if (dec & ~inc & ~zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/y86_regfile_sb.sv
// y86_regfile_sb: Y86 register file with two read ports, two write-back ports and a pending-write scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module y86_regfile_sb
  import y86_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 15,
  parameter int                ADDR_W   = 4,
  parameter int                MAX_INFL = 3,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic              issue_vld,
  input  logic [ADDR_W-1:0] issue_dstE,
  input  logic [ADDR_W-1:0] issue_dstM,
  output logic              stall,
  input  logic              wb_vld,
  input  logic [ADDR_W-1:0] wb_dstE,
  input  logic [ADDR_W-1:0] wb_dstM,
  input  logic [DATA_W-1:0] wb_valE,
  input  logic [DATA_W-1:0] wb_valM,
  output logic              sb_err
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  inc, dec, zero, full, uflow;
  logic [DATA_W-1:0] arr_a, arr_b;
  logic              busy_a, busy_b, fwd_a, fwd_b, full_hit, issue_acc;
  logic              ie_ok, im_ok, we_ok, wm_ok;

  assign ie_ok = !is_none(32'(issue_dstE), NREGS);
  assign im_ok = !is_none(32'(issue_dstM), NREGS);
  assign we_ok = !is_none(32'(wb_dstE), NREGS);
  assign wm_ok = !is_none(32'(wb_dstM), NREGS);

  // Out-of-range indices match no entry, so they read as 0 and are never busy.
  always_comb begin
    arr_a  = '0;
    arr_b  = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (srcA == ADDR_W'(r)) begin
        arr_a  = regs[r];
        busy_a = ~zero[r];
      end
      if (srcB == ADDR_W'(r)) begin
        arr_b  = regs[r];
        busy_b = ~zero[r];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [NREGS-1:0] last;
  logic             last_a, last_b;

  always_comb begin
    last_a = 1'b0;
    last_b = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (srcA == ADDR_W'(r)) last_a = last[r];
      if (srcB == ADDR_W'(r)) last_b = last[r];
    end
  end

  // Forward only when the retiring write is the last one outstanding.
  assign fwd_a = wb_vld & last_a & ((srcA == wb_dstM) | (srcA == wb_dstE));
  assign fwd_b = wb_vld & last_b & ((srcB == wb_dstM) | (srcB == wb_dstE));
  assign valA  = fwd_a ? ((srcA == wb_dstM) ? wb_valM : wb_valE) : arr_a;
  assign valB  = fwd_b ? ((srcB == wb_dstM) ? wb_valM : wb_valE) : arr_b;
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
  assign valA  = arr_a;
  assign valB  = arr_b;
`endif

  always_comb begin
    dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = wb_vld & ((we_ok & (wb_dstE == ADDR_W'(r))) |
                         (wm_ok & (wb_dstM == ADDR_W'(r))));
    end
  end

  // A full register may still accept a tag if it retires one in the same cycle.
  always_comb begin
    full_hit = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (full[r] & ~dec[r] &
          ((issue_dstE == ADDR_W'(r)) | (issue_dstM == ADDR_W'(r)))) begin
        full_hit = 1'b1;
      end
    end
  end

  assign stall     = issue_vld & ((busy_a & ~fwd_a) | (busy_b & ~fwd_b) | full_hit);
  assign issue_acc = issue_vld & ~stall;

  always_comb begin
    inc = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = issue_acc & ((ie_ok & (issue_dstE == ADDR_W'(r))) |
                            (im_ok & (issue_dstM == ADDR_W'(r))));
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_cnt
    y86_sb_counter #(
      .MAX(MAX_INFL)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[r]),
      .dec      (dec[r]),
      .zero     (zero[r]),
      .full     (full[r]),
      .underflow(uflow[r])
`ifdef REGFILE_BYPASS_EN
      ,
      .last     (last[r])
`endif
    );
  end

  // M port wins when both write-back ports target the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= (r == int'(RSP)) ? RSP_INIT : '0;
      end
    end else if (wb_vld) begin
      for (int r = 0; r < NREGS; r++) begin
        if (wb_dstM == ADDR_W'(r)) begin
          regs[r] <= wb_valM;
        end else if (wb_dstE == ADDR_W'(r)) begin
          regs[r] <= wb_valE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (|uflow) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// tb_y86_regfile_sb: scoreboard bench for y86_regfile_sb, directed scenarios then randomized traffic.
module tb_y86_regfile_sb;
  import y86_pkg::*;

  localparam int          DW   = 64;
  localparam int          NR   = 15;
  localparam int          AW   = 4;
  localparam int          MI   = 3;
  localparam logic [63:0] RSPI = 64'h100;
  localparam logic [3:0]  N    = 4'hF;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] srcA = N, srcB = N, issue_dstE = N, issue_dstM = N, wb_dstE = N, wb_dstM = N;
  logic [DW-1:0] valA, valB, wb_valE = '0, wb_valM = '0;
  logic          issue_vld = 1'b0, wb_vld = 1'b0, stall, sb_err;

  always #5 clk = ~clk;

  y86_regfile_sb #(
    .DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .MAX_INFL(MI), .RSP_INIT(RSPI)
  ) dut (
    .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .issue_vld(issue_vld), .issue_dstE(issue_dstE), .issue_dstM(issue_dstM), .stall(stall),
    .wb_vld(wb_vld), .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_valE(wb_valE), .wb_valM(wb_valM),
    .sb_err(sb_err)
  );

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic        st;
    logic        er;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  // Reference model: architectural contents, outstanding-write counts, sticky error.
  logic [63:0] m_reg[NR];
  int          m_cnt[NR];
  bit          m_err;

  function automatic bit ok(input logic [3:0] i);
    return int'(i) < NR;
  endfunction

  function automatic int cnt_of(input logic [3:0] i);
    return ok(i) ? m_cnt[int'(i)] : 0;
  endfunction

  function automatic logic [63:0] reg_of(input logic [3:0] i);
    return ok(i) ? m_reg[int'(i)] : 64'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      m_reg[k] = (k == int'(RSP)) ? RSPI : 64'h0;
      m_cnt[k] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic bit dst_full(input logic [3:0] d, input bit wv, input logic [3:0] we,
                                  input logic [3:0] wm);
    return ok(d) && cnt_of(d) == MI && !(wv && (d == we || d == wm));
  endfunction

  task automatic step(input bit r, input logic [3:0] sa, input logic [3:0] sb,
                      input bit iv, input logic [3:0] ie, input logic [3:0] im,
                      input bit wv, input logic [3:0] we, input logic [3:0] wm,
                      input logic [63:0] ve, input logic [63:0] vm,
                      input string nm, output bit acc);
    exp_t e;
    bit   fa, fb;
    int   d;
    @(posedge clk);
    #1;
    rst = r; srcA = sa; srcB = sb;
    issue_vld = iv; issue_dstE = ie; issue_dstM = im;
    wb_vld = wv; wb_dstE = we; wb_dstM = wm; wb_valE = ve; wb_valM = vm;
    if (r) model_reset();
    fa = BYP && wv && cnt_of(sa) == 1 && (sa == wm || sa == we);
    fb = BYP && wv && cnt_of(sb) == 1 && (sb == wm || sb == we);
    e.va = fa ? ((sa == wm) ? vm : ve) : reg_of(sa);
    e.vb = fb ? ((sb == wm) ? vm : ve) : reg_of(sb);
    e.st = iv && ((cnt_of(sa) != 0 && !fa) || (cnt_of(sb) != 0 && !fb) ||
                  dst_full(ie, wv, we, wm) || dst_full(im, wv, we, wm));
    e.er = m_err;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    acc = iv && !e.st && !r;
    if (!r) begin
      for (int k = 0; k < NR; k++) begin
        d = 0;
        if (acc && (int'(ie) == k || int'(im) == k)) d = d + 1;
        if (wv && (int'(we) == k || int'(wm) == k)) d = d - 1;
        if (d < 0) begin
          if (m_cnt[k] == 0) m_err = 1'b1;
          else m_cnt[k] = m_cnt[k] - 1;
        end else begin
          m_cnt[k] = m_cnt[k] + d;
        end
      end
      if (wv && ok(we)) m_reg[int'(we)] = ve;
      if (wv && ok(wm)) m_reg[int'(wm)] = vm;
    end
  endtask

  task automatic idle(input string nm);
    bit a;
    step(1'b0, N, N, 1'b0, N, N, 1'b0, N, N, 64'h0, 64'h0, nm, a);
  endtask

  function automatic void chk(input string nm, input string f, input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, exp);
    end
  endfunction

  exp_t  mon_e;
  string mon_nm;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = nm_q.pop_front();
        chk(mon_nm, "valA", valA, mon_e.va);
        chk(mon_nm, "valB", valB, mon_e.vb);
        chk(mon_nm, "stall", {63'h0, stall}, {63'h0, mon_e.st});
        chk(mon_nm, "sb_err", {63'h0, sb_err}, {63'h0, mon_e.er});
      end
    end
  end

  logic [3:0] pe[$], pm[$];
  bit         a, have, iv;
  logic [3:0] c_sa, c_sb, c_ie, c_im, we, wm;
  bit         wv;

  initial begin
    model_reset();
    // reset, then async reset arriving between clock edges
    step(1, 4, 0, 0, N, N, 0, N, N, 0, 0, "reset", a);
    step(0, 4, 0, 0, N, N, 0, N, N, 0, 0, "reset_hold", a);
    step(0, N, N, 1, 4, 0, 0, N, N, 0, 0, "iss_4_0", a);
    step(0, N, N, 0, N, N, 1, 4, 0, 64'hAAAA, 64'h77, "wb_4_0", a);
    step(0, 4, 0, 0, N, N, 0, N, N, 0, 0, "rd_4_0", a);
    step(1, 4, 0, 0, N, N, 0, N, N, 0, 0, "async_rst", a);
    step(0, 4, 0, 0, N, N, 0, N, N, 0, 0, "rst_release", a);
    // read-after-write hazard on reg 3
    step(0, N, N, 1, 3, N, 0, N, N, 0, 0, "iss_3", a);
    step(0, 3, N, 1, N, N, 0, N, N, 0, 0, "raw_3", a);
    step(0, 3, N, 1, N, N, 1, 3, N, 64'h55, 64'h0, "raw_3_wb", a);
    step(0, 3, N, 1, N, N, 0, N, N, 0, 0, "raw_3_after", a);
    // both write-back ports to reg 2
    step(0, N, N, 1, 2, 2, 0, N, N, 0, 0, "iss_2_2", a);
    step(0, N, N, 0, N, N, 1, 2, 2, 64'h11, 64'h22, "wb_2_2", a);
    step(0, 2, N, 1, N, N, 0, N, N, 0, 0, "rd_2", a);
    // saturation at MAX_INFL on reg 5
    repeat (3) step(0, N, N, 1, 5, N, 0, N, N, 0, 0, "iss_5", a);
    step(0, N, N, 1, 5, N, 0, N, N, 0, 0, "iss_5_full", a);
    step(0, N, N, 1, 5, N, 1, 5, N, 64'h99, 64'h0, "iss_5_wb", a);
    step(0, N, N, 1, 5, N, 0, N, N, 0, 0, "iss_5_still_full", a);
    step(0, 5, N, 0, N, N, 1, 5, N, 64'h91, 64'h0, "drain_5a", a);
    step(0, 5, N, 0, N, N, 1, 5, N, 64'h92, 64'h0, "drain_5b", a);
    step(0, 5, N, 0, N, N, 1, 5, N, 64'h93, 64'h0, "drain_5c", a);
    step(0, 5, N, 1, N, N, 0, N, N, 0, 0, "rd_5", a);
    // underflow is sticky until reset
    step(0, N, N, 0, N, N, 1, 6, N, 64'h66, 64'h0, "uflow_6", a);
    repeat (3) idle("err_sticky");
    step(1, 6, N, 0, N, N, 0, N, N, 0, 0, "err_rst", a);
    step(0, 6, N, 0, N, N, 0, N, N, 0, 0, "err_rst_release", a);
    // RNONE everywhere is inert
    step(0, N, N, 1, N, N, 1, N, N, 64'h123, 64'h456, "none_wb", a);
    step(0, N, 4, 0, N, N, 0, N, N, 0, 0, "none_after", a);

    have = 1'b0;
    c_sa = N; c_sb = N; c_ie = N; c_im = N; iv = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!have) begin
        iv   = ($urandom_range(0, 3) != 0);
        c_sa = 4'($urandom_range(0, 15));
        c_sb = 4'($urandom_range(0, 15));
        c_ie = 4'($urandom_range(0, 15));
        c_im = 4'($urandom_range(0, 15));
      end
      wv = (pe.size() > 0) && ($urandom_range(0, 1) == 1);
      we = N; wm = N;
      if (wv) begin
        we = pe.pop_front();
        wm = pm.pop_front();
      end
      step(0, c_sa, c_sb, iv, c_ie, c_im, wv, we, wm, {$urandom, $urandom}, {$urandom, $urandom},
           "rand", a);
      if (a) begin
        pe.push_back(c_ie);
        pm.push_back(c_im);
      end
      have = iv && !a;
    end
    idle("final");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
